// File: rtl/alu_wide_seq_pkg.sv
// Shared op encodings for the 32-bit ALU and the 64-bit wide sequencer.
// WIDE_ALU_COMP_EN adds the result-suppress flag to the decoded op map.
package alu_wide_seq_pkg;

    localparam int WORD_W = 32;
    localparam int WIDE_W = 64;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,
        OP_ADDC = 5'd1,
        OP_SUB  = 5'd2,
        OP_SUBC = 5'd3,
        OP_AND  = 5'd4,
        OP_OR   = 5'd5,
        OP_XOR  = 5'd6
    } alu_op_e;

    typedef enum logic [2:0] {
        WIDE_ADD  = 3'd0,
        WIDE_SUB  = 3'd1,
        WIDE_AND  = 3'd2,
        WIDE_OR   = 3'd3,
        WIDE_XOR  = 3'd4,
        WIDE_COMP = 3'd5
    } wide_op_e;

    typedef struct packed {
        alu_op_e lo_op;
        alu_op_e hi_op;
`ifdef WIDE_ALU_COMP_EN
        logic    suppress_result;
`endif
        logic    valid;
    } opmap_t;

endpackage

// File: rtl/alu_wide_seq_opmap.sv
// Combinational decode of a wide op into per-half ALU ops.
// COMP decodes as valid only when WIDE_ALU_COMP_EN is defined.
module alu_wide_opmap
    import alu_wide_seq_pkg::*;
(
    input  logic [2:0] wide_op_i,
    output opmap_t     map_o
);

    // Translate the wide op into low/high ALU ops and a validity flag.
    always_comb begin
        map_o.lo_op = OP_ADD;
        map_o.hi_op = OP_ADD;
`ifdef WIDE_ALU_COMP_EN
        map_o.suppress_result = 1'b0;
`endif
        map_o.valid = 1'b0;
        case (wide_op_i)
            WIDE_ADD: begin
                map_o.lo_op = OP_ADD;
                map_o.hi_op = OP_ADDC;
                map_o.valid = 1'b1;
            end
            WIDE_SUB: begin
                map_o.lo_op = OP_SUB;
                map_o.hi_op = OP_SUBC;
                map_o.valid = 1'b1;
            end
            WIDE_AND: begin
                map_o.lo_op = OP_AND;
                map_o.hi_op = OP_AND;
                map_o.valid = 1'b1;
            end
            WIDE_OR: begin
                map_o.lo_op = OP_OR;
                map_o.hi_op = OP_OR;
                map_o.valid = 1'b1;
            end
            WIDE_XOR: begin
                map_o.lo_op = OP_XOR;
                map_o.hi_op = OP_XOR;
                map_o.valid = 1'b1;
            end
`ifdef WIDE_ALU_COMP_EN
            WIDE_COMP: begin
                map_o.lo_op = OP_SUB;
                map_o.hi_op = OP_SUBC;
                map_o.suppress_result = 1'b1;
                map_o.valid = 1'b1;
            end
`endif
            default: begin
                map_o.valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_wide_seq.sv
// 64-bit op sequencer driving a registered 32-bit ALU low word then high word.
// WIDE_ALU_COMP_EN enables COMP (compare: flags only, result returns operand a).
module alu_wide_seq
    import alu_wide_seq_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  wide_op,
    input  logic [63:0] a_in,
    input  logic [63:0] b_in,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [63:0] result,
    output logic        carry,
    output logic        zero,
    output logic        neg,
    output logic        over,
    output logic [4:0]  alu_op,
    output logic [31:0] alu_reg2,
    output logic [31:0] alu_reg3,
    output logic        alu_carry_in,
    input  logic [31:0] alu_result,
    input  logic        alu_carry_out,
    input  logic        alu_zero_out,
    input  logic        alu_neg_out,
    input  logic        alu_over_out
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LO_EXEC = 3'd1,
        S_LO_CAPT = 3'd2,
        S_HI_EXEC = 3'd3,
        S_HI_CAPT = 3'd4
    } state_e;

    state_e      state_q;
    opmap_t      map_s;
    logic [31:0] a_hi_q, b_hi_q, lo_res_q;
    logic [4:0]  hi_op_q, alu_op_q;
    logic [31:0] alu_reg2_q, alu_reg3_q;
    logic        alu_carry_in_q, lo_zero_q;
    logic        busy_q, done_q, err_q;
    logic [63:0] result_q;
    logic        carry_q, zero_q, neg_q, over_q;
`ifdef WIDE_ALU_COMP_EN
    logic [31:0] a_lo_q;
    logic        suppress_q;
`endif

    alu_wide_opmap u_opmap (
        .wide_op_i (wide_op),
        .map_o     (map_s)
    );

    // Sequencer FSM: the ALU has one registered cycle, so each half spends one EXEC and one CAPT cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_IDLE;
            a_hi_q         <= 32'd0;
            b_hi_q         <= 32'd0;
            lo_res_q       <= 32'd0;
            lo_zero_q      <= 1'b0;
            hi_op_q        <= 5'd0;
            alu_op_q       <= 5'd0;
            alu_reg2_q     <= 32'd0;
            alu_reg3_q     <= 32'd0;
            alu_carry_in_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            result_q       <= 64'd0;
            carry_q        <= 1'b0;
            zero_q         <= 1'b0;
            neg_q          <= 1'b0;
            over_q         <= 1'b0;
`ifdef WIDE_ALU_COMP_EN
            a_lo_q         <= 32'd0;
            suppress_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && map_s.valid) begin
                        a_hi_q         <= a_in[63:32];
                        b_hi_q         <= b_in[63:32];
                        hi_op_q        <= map_s.hi_op;
                        alu_op_q       <= map_s.lo_op;
                        alu_reg2_q     <= a_in[31:0];
                        alu_reg3_q     <= b_in[31:0];
                        alu_carry_in_q <= 1'b0;
                        busy_q         <= 1'b1;
                        state_q        <= S_LO_EXEC;
`ifdef WIDE_ALU_COMP_EN
                        a_lo_q         <= a_in[31:0];
                        suppress_q     <= map_s.suppress_result;
`endif
                    end else if (start) begin
                        err_q <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_LO_EXEC: state_q <= S_LO_CAPT;
                S_LO_CAPT: begin
                    lo_res_q       <= alu_result;
                    lo_zero_q      <= alu_zero_out;
                    alu_op_q       <= hi_op_q;
                    alu_reg2_q     <= a_hi_q;
                    alu_reg3_q     <= b_hi_q;
                    alu_carry_in_q <= alu_carry_out;
                    state_q        <= S_HI_EXEC;
                end
                S_HI_EXEC: state_q <= S_HI_CAPT;
                S_HI_CAPT: begin
`ifdef WIDE_ALU_COMP_EN
                    result_q <= suppress_q ? {a_hi_q, a_lo_q} : {alu_result, lo_res_q};
`else
                    result_q <= {alu_result, lo_res_q};
`endif
                    carry_q <= alu_carry_out;
                    neg_q   <= alu_neg_out;
                    over_q  <= alu_over_out;
                    zero_q  <= lo_zero_q & alu_zero_out;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign result       = result_q;
    assign carry        = carry_q;
    assign zero         = zero_q;
    assign neg          = neg_q;
    assign over         = over_q;
    assign alu_op       = alu_op_q;
    assign alu_reg2     = alu_reg2_q;
    assign alu_reg3     = alu_reg3_q;
    assign alu_carry_in = alu_carry_in_q;

endmodule

// File: doc/alu_wide_seq.md
# alu_wide_seq

Multi-cycle sequencer that performs 64-bit arithmetic and logic operations by driving the 32-bit ALU twice: low word first, then high word, with the ALU carry chained between them. It is the initiator side of the ALU interface. It registers the ALU operand and op inputs, captures the ALU result and flags, and presents a 64-bit result with merged flags through a start/busy/done handshake. It sits between the execute stage and the single-word ALU.

## Interface
Parameters:
- none. Word width is fixed at 32; the wide width is 64.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request strobe; sampled only in IDLE.
- wide_op  in  3  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 COMP, 6–7 invalid.
- a_in, b_in  in  64 each  operands; sampled on the accepting edge.
- busy  out  1  high while a request is in flight.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse instead of done for an invalid op.
- result  out  64  wide result.
- carry, zero, neg, over  out  1 each  merged flags.
- alu_op  out  5  registered op driven to the ALU.
- alu_reg2, alu_reg3  out  32 each  registered ALU operands.
- alu_carry_in  out  1  registered ALU carry input.
- alu_result  in  32  ALU result.
- alu_carry_out, alu_zero_out, alu_neg_out, alu_over_out  in  1 each  ALU flags.

## Operation
- Op mapping, as low op / high op:
  - ADD → OP_ADD / OP_ADDC.
  - SUB → OP_SUB / OP_SUBC.
  - COMP → OP_SUB / OP_SUBC, with the result write suppressed.
  - AND, OR, XOR → the same op on both halves.
- alu_carry_in is 0 for the low half. For the high half it is the alu_carry_out captured from the low half.
- FSM states: IDLE, LO_EXEC, LO_CAPT, HI_EXEC, HI_CAPT.
- IDLE, on start with a valid op:
  - latch a_in and b_in.
  - drive alu_reg2 = a[31:0], alu_reg3 = b[31:0], and the low op.
  - go to LO_EXEC.
- IDLE, on start with an invalid op: pulse err next cycle, make no ALU transaction, stay in IDLE.
- LO_EXEC: hold the ALU inputs; the ALU samples them on this edge. Go to LO_CAPT.
- LO_CAPT:
  - capture alu_result as lo_res and alu_zero_out as lo_zero.
  - drive a[63:32], b[63:32], the high op, and alu_carry_in = alu_carry_out.
  - go to HI_EXEC.
- HI_EXEC: hold the ALU inputs. Go to HI_CAPT.
- HI_CAPT:
  - register result = {alu_result, lo_res}. For COMP, result = latched a instead.
  - register carry = alu_carry_out, neg = alu_neg_out, over = alu_over_out.
  - register zero = lo_zero & alu_zero_out.
  - pulse done and go to IDLE.
- result and the flags hold their values until the next completion.
- start outside IDLE is ignored; it is not queued.
- When ALU inputs are not in use, alu_op is held at its last value. The ALU output is don't-care in IDLE.

## Timing
- With start sampled at the end of cycle 0:
  - busy is high in cycles 1–4.
  - done is high in cycle 5 only.
  - result and flags become valid in cycle 5.
- Back-to-back: start may be asserted in the cycle where done is high. The next done then comes 5 cycles later, so throughput is one operation per 5 cycles.
- err is high in the cycle after an invalid start. busy stays 0.
- The ALU is assumed to have one registered cycle of latency: inputs held through an *_EXEC edge give outputs during *_CAPT.
- Reset values: state IDLE; busy, done, err, carry, zero, neg, over all 0; result 0; alu_op 0, alu_reg2 0, alu_reg3 0, alu_carry_in 0.
- Reset mid-operation: return to IDLE on the next edge, with no done and no err. The partial lo_res is discarded.

## Configuration
- WIDE_ALU_COMP_EN defined: wide_op 5 performs COMP as described above.
- WIDE_ALU_COMP_EN undefined: wide_op 5 is invalid and produces an err pulse. The result-suppress path and the latched-a mux are not built.

## Structure
- The shared package/header alu.vh holds:
  - the ALU op codes (OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_AND, OP_OR, OP_XOR).
  - the new wide_op encodings WIDE_ADD … WIDE_COMP.
- The state encoding stays local to the module.
- One sub-module, alu_wide_opmap: combinational decode of wide_op into {lo_op, hi_op, suppress_result, valid}.
- The bench instantiates the real ALU against alu_wide_seq.

## Test plan
- ADD a=0x00000000_FFFFFFFF, b=1 → result 0x00000001_00000000; carry 0, zero 0, neg 0, over 0; done in cycle 5; busy in cycles 1–4.
- ADD a=0xFFFFFFFF_FFFFFFFF, b=1 → result 0; carry 1, zero 1, neg 0.
- SUB a=0x80000000_00000000, b=1 → result 0x7FFFFFFF_FFFFFFFF; over 1, neg 0, carry 0. Low-half borrow appears on alu_carry_in during HI_EXEC.
- AND a=b=0x00000001_00000000 → zero 0, even though the low half is zero. XOR a=0xFFFF0000_0000FFFF, b=0x0000FFFF_FFFF0000 → all ones, neg 1.
- COMP a=b=0x12345678_9ABCDEF0 → with macro defined: result = a, zero 1, carry 0. With macro undefined: err pulse in cycle 1, result unchanged.
- Start ADD, assert reset in HI_EXEC, and re-pulse start during busy → no done; busy 0 after reset; all outputs 0; the mid-flight start is ignored.
